cnn: RTL and testbench
======================

Name: cnn

Overview:
- Single-layer convolution engine.
- Convolves a 16x16 8-bit unsigned image with KERNEL_COUNT 4x4 signed kernels, using valid convolution with stride 1 (13x13 outputs per kernel).
- Source data comes from an internal unified RAM. Each kernel's activated, saturated 8-bit results go to its own output bank.
- Sits behind a simple start/done handshake. Address bases are supplied by the controller.

Parameters:
- KERNEL_COUNT, 4: number of kernels and of output banks.
- INIT_FILE, "cnn_mem.hex": hex file loaded into the source RAM via $readmemh at time 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- start  input  1  begin job; sampled in IDLE or DONE.
- x  input  AW  image base address in the source RAM.
- y  input  AW  kernel block base address in the source RAM.
- z  input  8  base address within each output bank.
- done  output  1  high while the FSM is in DONE.
- AW = $clog2(KERNEL_COUNT*16+256); AW = 9 for the default.

Behaviour:
- Source RAM:
  - 2^AW words of 8 bits, combinational read.
  - All address arithmetic wraps modulo 2^AW.
- Output banks:
  - KERNEL_COUNT banks, each 256 x 8 bits.
  - Write-only from the datapath; inspected hierarchically by the bench.
- Data types: pixels are unsigned 8-bit; weights are signed 8-bit.
- Addressing:
  - Pixel address: x + (i+kr)*16 + (j+kc).
  - Weight address: y + k*16 + kr*4 + kc.
  - Output address in bank k: (z + i*13 + j) mod 256.
- Loop order, outermost first: k 0..KERNEL_COUNT-1, then i 0..12, then j 0..12, then kr 0..3, then kc 0..3.
- Accumulator:
  - 21-bit signed; cleared at the start of each window.
  - Each product is zero-extended pixel x sign-extended weight.
- FSM states: IDLE, CONV, WRITE, DONE.
  - IDLE: start=1 captures x, y, z, clears all counters and the accumulator, and moves to CONV.
  - CONV: one MAC per cycle, 16 cycles per window, then WRITE.
  - WRITE: one cycle. Stores the activated result, clears the accumulator, and advances j/i/k. Goes to CONV, or to DONE after the last window.
  - DONE: done=1. start=1 restarts exactly as from IDLE; otherwise the FSM holds.
- Timing:
  - 17 cycles per window.
  - Counting the start-sampling edge as edge 0, done is high after edge KERNEL_COUNT*169*17 (11492 for the default).
- Activation:
  - Negative accumulator values give 0.
  - Values above 255 saturate to 255.
  - Otherwise the low 8 bits are written.
- Inputs x, y, z, start are ignored while in CONV or WRITE. Captured bases are used for the whole job.
- Reset (rst=0 at a clock edge):
  - State goes to IDLE, done=0, counters and accumulator are cleared.
  - Effective mid-job; the partial job is abandoned.
  - Output banks and source RAM keep their contents.

Optional Feature:
- CNN_RELU_EN defined: activation as above (ReLU, then saturate to 0..255).
- CNN_RELU_EN undefined: signed saturation to -128..127, stored as two's complement.
- Cycle timing is identical either way.

Decomposition:
- Package cnn_pkg holds:
  - IMG_DIM=16, K_DIM=4, OUT_DIM=13, ACC_W=21.
  - State enum type.
  - Activation/saturation function.
- One sub-module, cnn_mac: 8x8 mixed-sign multiply into a 21-bit accumulator, with clear and enable inputs.
- FSM, counters, RAM and banks stay in cnn.

Test Plan:
- Common setup for each test: x=0, y=268, z=0, one-cycle start after reset release.
- Test 1, all ones:
  - Stimulus: image all 1, kernel weights all 1.
  - Expected: every bank entries 0..168 = 16; done exactly after edge 11492.
- Test 2, ramp image:
  - Stimulus: image pixel(r,c)=r+c. Kernel 0 has weight 2 at (0,0) and 0 elsewhere.
  - Expected: bank0[i*13+j] = 2*(i+j), e.g. entry 168 = 48.
- Test 3, negative weights:
  - Stimulus: all weights -1, pixels 1.
  - Expected: all outputs 0; without CNN_RELU_EN, 0xF0 (-16).
- Test 4, saturation:
  - Stimulus: pixels 255, weights 127.
  - Expected: all outputs 255; without CNN_RELU_EN, 127.
- Test 5, reset mid-job:
  - Stimulus: rst=0 for one edge at cycle 3000.
  - Expected: done=0 and FSM in IDLE after that edge. A new start completes normally with correct results.
- Test 6, wrap-around:
  - Stimulus: z=200.
  - Expected: entry (i,j)=(12,12) lands at bank address (200+168) mod 256 = 112. A kernel base y=500 wraps kernel 1 to address 4.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and output activation for the cnn convolution engine.
// Macro CNN_RELU_EN selects ReLU + unsigned saturation; undefined gives signed saturation.
package cnn_pkg;

   localparam int IMG_DIM = 16;
   localparam int K_DIM   = 4;
   localparam int OUT_DIM = 13;
   localparam int ACC_W   = 21;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      WRITE,
      DONE
   } state_e;

   function automatic logic [7:0] activate(input logic signed [ACC_W-1:0] acc);
      logic [7:0] res;
`ifdef CNN_RELU_EN
      if (acc < 0)
         res = 8'h00;
      else if (acc > 21'sd255)
         res = 8'hFF;
      else
         res = acc[7:0];
`else
      if (acc < -21'sd128)
         res = 8'h80;
      else if (acc > 21'sd127)
         res = 8'h7F;
      else
         res = acc[7:0];
`endif
      return res;
   endfunction

endpackage

// File: rtl/cnn_mac.sv
// Mixed-sign multiply-accumulate: unsigned 8-bit pixel times signed 8-bit weight into a 21-bit accumulator.
module cnn_mac
   import cnn_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic [7:0]              pixel_i,
   input  logic signed [7:0]       weight_i,
   output logic signed [ACC_W-1:0] acc_o
);

   logic signed [16:0]      prod;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;

   // The pixel gets a zero sign bit so the product stays a true mixed-sign multiply.
   always_comb begin
      prod  = $signed({1'b0, pixel_i}) * weight_i;
      acc_d = acc_q + ACC_W'(prod);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         acc_q <= '0;
      else if (clr_i)
         acc_q <= '0;
      else if (en_i)
         acc_q <= acc_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/cnn.sv
// Single-layer 16x16 image / 4x4 kernel convolution engine with source RAM and per-kernel output banks.
// Activation mode is chosen by the CNN_RELU_EN macro (see cnn_pkg).
module cnn
   import cnn_pkg::*;
#(
   parameter int    KERNEL_COUNT = 4,
   parameter string INIT_FILE    = "cnn_mem.hex",
   localparam int   AW           = $clog2(KERNEL_COUNT*16 + 256)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] x,
   input  logic [AW-1:0] y,
   input  logic [7:0]    z,
   output logic          done
);

   localparam int KW = (KERNEL_COUNT > 1) ? $clog2(KERNEL_COUNT) : 1;

   logic [7:0] srcMem  [2**AW];
   logic [7:0] bankMem [KERNEL_COUNT][256];

   state_e        state_q;
   logic          done_q;
   logic [AW-1:0] xBase_q;
   logic [AW-1:0] yBase_q;
   logic [7:0]    zBase_q;
   logic [KW-1:0] kIdx_q;
   logic [3:0]    row_q;
   logic [3:0]    col_q;
   logic [3:0]    tap_q;

   logic [4:0]              pixRow;
   logic [4:0]              pixCol;
   logic [AW-1:0]           pixAddr;
   logic [AW-1:0]           wgtAddr;
   logic [7:0]              outAddr;
   logic                    accept;
   logic signed [ACC_W-1:0] acc;

   // tap_q walks the kernel row-major, so its top bits are kr and bottom bits kc.
   always_comb begin
      pixRow  = {1'b0, row_q} + {3'b0, tap_q[3:2]};
      pixCol  = {1'b0, col_q} + {3'b0, tap_q[1:0]};
      pixAddr = xBase_q + AW'(pixRow * IMG_DIM) + AW'(pixCol);
      wgtAddr = yBase_q + AW'(kIdx_q * (K_DIM*K_DIM)) + AW'(tap_q);
      outAddr = zBase_q + ({4'b0, row_q} * 8'(OUT_DIM)) + {4'b0, col_q};
      accept  = start && (state_q == IDLE || state_q == DONE);
   end

   cnn_mac u_mac (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (accept || state_q == WRITE),
      .en_i     (state_q == CONV),
      .pixel_i  (srcMem[pixAddr]),
      .weight_i ($signed(srcMem[wgtAddr])),
      .acc_o    (acc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         xBase_q <= '0;
         yBase_q <= '0;
         zBase_q <= '0;
         kIdx_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         tap_q   <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= CONV;
                  done_q  <= 1'b0;
                  xBase_q <= x;
                  yBase_q <= y;
                  zBase_q <= z;
                  kIdx_q  <= '0;
                  row_q   <= '0;
                  col_q   <= '0;
                  tap_q   <= '0;
               end
            end
            CONV: begin
               tap_q <= tap_q + 4'd1;
               if (tap_q == 4'(K_DIM*K_DIM - 1))
                  state_q <= WRITE;
            end
            WRITE: begin
               state_q <= CONV;
               if (col_q != 4'(OUT_DIM - 1)) begin
                  col_q <= col_q + 4'd1;
               end else begin
                  col_q <= '0;
                  if (row_q != 4'(OUT_DIM - 1)) begin
                     row_q <= row_q + 4'd1;
                  end else begin
                     row_q <= '0;
                     if (kIdx_q == KW'(KERNEL_COUNT - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        kIdx_q <= kIdx_q + 1'b1;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Banks are deliberately outside the reset domain so results survive an aborted job.
   always_ff @(posedge clk) begin
      if (state_q == WRITE)
         bankMem[kIdx_q][outAddr] <= activate(acc);
   end

   assign done = done_q;

endmodule

// File: tb/tb_cnn.sv
// Scoreboard bench for cnn: a shadow copy of the source RAM feeds a reference convolution whose results are queued and compared against the banks.
module tb_cnn;
   import cnn_pkg::*;

   localparam int KC        = 4;
   localparam int MEMW      = 512;
   localparam int JOB_EDGES = KC * 169 * 17;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [8:0] x = '0;
   logic [8:0] y = '0;
   logic [7:0] z = '0;
   logic       done;

   int checks = 0;
   int failures = 0;

   logic [7:0] shadow [MEMW];

   typedef struct {
      int         bank;
      int         addr;
      logic [7:0] data;
   } exp_t;
   exp_t expQ[$];

   cnn #(.KERNEL_COUNT(KC), .INIT_FILE("")) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .y     (y),
      .z     (z),
      .done  (done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] refAct(input int acc);
`ifdef CNN_RELU_EN
      if (acc < 0) return 8'd0;
      if (acc > 255) return 8'd255;
`else
      if (acc < -128) return 8'h80;
      if (acc > 127) return 8'h7F;
`endif
      return acc[7:0];
   endfunction

   task automatic writeMem(input int a, input int v);
      shadow[a % MEMW] = 8'(v);
      dut.srcMem[a % MEMW] = 8'(v);
   endtask

   task automatic pushExpected(input int xb, input int yb, input int zb);
      for (int k = 0; k < KC; k++)
         for (int i = 0; i < 13; i++)
            for (int j = 0; j < 13; j++) begin
               int   acc;
               exp_t e;
               acc = 0;
               for (int kr = 0; kr < 4; kr++)
                  for (int kc = 0; kc < 4; kc++) begin
                     int p;
                     int w;
                     p = int'(shadow[(xb + (i + kr) * 16 + j + kc) % MEMW]);
                     w = int'($signed(shadow[(yb + k * 16 + kr * 4 + kc) % MEMW]));
                     acc += p * w;
                  end
               e.bank = k;
               e.addr = (zb + i * 13 + j) % 256;
               e.data = refAct(acc);
               expQ.push_back(e);
            end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic startJob(input int xb, input int yb, input int zb);
      x = 9'(xb);
      y = 9'(yb);
      z = 8'(zb);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int already, output int n);
      n = already;
      while (done !== 1'b1 && n < JOB_EDGES + 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL done_timeout: done=%b after %0d edges, required 1 at edge %0d", done, n, JOB_EDGES);
      end
   endtask

   task automatic checkDoneEdge(input string name, input int n);
      checks++;
      if (n !== JOB_EDGES) begin
         failures++;
         $display("[TB] FAIL %s_done_edge: done first high after edge %0d, required %0d", name, n, JOB_EDGES);
      end
   endtask

   task automatic drainScoreboard(input string name);
      exp_t e;
      logic [7:0] got;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         got = dut.bankMem[e.bank][e.addr];
         checks++;
         if (got !== e.data) begin
            failures++;
            $display("[TB] FAIL %s bank%0d[%0d]: got 0x%02h expected 0x%02h", name, e.bank, e.addr, got, e.data);
         end
      end
   endtask

   task automatic test_reset();
      applyReset();
      #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_done: got %b expected 0", done);
      end
      checks++;
      if (dut.state_q !== IDLE) begin
         failures++;
         $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
      end
   endtask

   task automatic test_all_ones();
      int n;
      applyReset();
      for (int a = 0; a < 256; a++) writeMem(a, 1);
      for (int t = 0; t < 16; t++) begin
         writeMem(268 + t, 1);
         writeMem(268 + 16 + t, 1);
         writeMem(268 + 32 + t, 8'hFF);
         writeMem(268 + 48 + t, 8'hFF);
      end
      pushExpected(0, 268, 0);
      startJob(0, 268, 0);
      waitDone(0, n);
      checkDoneEdge("all_ones", n);
      drainScoreboard("all_ones");
   endtask

   task automatic test_ramp();
      int n;
      logic [7:0] got;
      applyReset();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) writeMem(r * 16 + c, r + c);
      for (int k = 0; k < KC; k++)
         for (int t = 0; t < 16; t++)
            writeMem(268 + k * 16 + t, (k == 0 && t == 0) ? 2 : ((k > 0 && t == 5 * k % 16) ? k : 0));
      pushExpected(0, 268, 0);
      startJob(0, 268, 0);
      // Mid-job start and base changes must be ignored.
      for (int e = 0; e < 500; e++) begin
         @(posedge clk);
         #1;
      end
      x = 9'h1FF;
      y = 9'd0;
      z = 8'd77;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(501, n);
      checkDoneEdge("ramp", n);
      got = dut.bankMem[0][168];
      checks++;
      if (got !== 8'd48) begin
         failures++;
         $display("[TB] FAIL ramp_corner: got %0d expected 48", got);
      end
      drainScoreboard("ramp");
   endtask

   task automatic test_saturation();
      int n;
      logic [7:0] got;
      logic [7:0] hiExp;
      logic [7:0] loExp;
      applyReset();
      for (int a = 0; a < 256; a++) writeMem(a, 255);
      for (int t = 0; t < 16; t++) begin
         writeMem(268 + t, 127);
         writeMem(268 + 16 + t, 127);
         writeMem(268 + 32 + t, 8'h80);
         writeMem(268 + 48 + t, 8'h80);
      end
`ifdef CNN_RELU_EN
      hiExp = 8'd255;
      loExp = 8'd0;
`else
      hiExp = 8'd127;
      loExp = 8'h80;
`endif
      pushExpected(0, 268, 0);
      startJob(0, 268, 0);
      waitDone(0, n);
      checkDoneEdge("saturation", n);
      got = dut.bankMem[1][0];
      checks++;
      if (got !== hiExp) begin
         failures++;
         $display("[TB] FAIL sat_high: got 0x%02h expected 0x%02h", got, hiExp);
      end
      got = dut.bankMem[3][168];
      checks++;
      if (got !== loExp) begin
         failures++;
         $display("[TB] FAIL sat_low: got 0x%02h expected 0x%02h", got, loExp);
      end
      drainScoreboard("saturation");
   endtask

   task automatic test_reset_midjob();
      int n;
      applyReset();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) writeMem(r * 16 + c, (r * 5 + c) % 23);
      for (int k = 0; k < KC; k++)
         for (int t = 0; t < 16; t++) writeMem(268 + k * 16 + t, (t == k) ? 3 : ((t == 15 - k) ? 8'hFE : 0));
      startJob(0, 268, 0);
      repeat (2999) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midjob_reset_done: got %b expected 0", done);
      end
      checks++;
      if (dut.state_q !== IDLE) begin
         failures++;
         $display("[TB] FAIL midjob_reset_state: got %0d expected %0d", dut.state_q, IDLE);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (dut.state_q !== IDLE) begin
         failures++;
         $display("[TB] FAIL midjob_hold_idle: got %0d expected %0d", dut.state_q, IDLE);
      end
      pushExpected(0, 268, 0);
      startJob(0, 268, 0);
      waitDone(0, n);
      checkDoneEdge("restart", n);
      drainScoreboard("restart");
   endtask

   task automatic test_wrap();
      int n;
      applyReset();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) writeMem(52 + r * 16 + c, (r * 7 + c * 3) % 32);
      for (int k = 0; k < KC; k++)
         for (int t = 0; t < 16; t++) writeMem(500 + k * 16 + t, ((k * 5 + t * 3) % 7) - 3);
      pushExpected(52, 500, 200);
      startJob(52, 500, 200);
      waitDone(0, n);
      checkDoneEdge("wrap", n);
      drainScoreboard("wrap");
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_ramp();
      test_saturation();
      test_reset_midjob();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
